id_ex_reg: RTL and testbench

- Decode-to-execute pipeline register of the 5-stage RISC-V core; sits directly upstream of the ALU controller and ALU.
- Captures decoded operands, immediate, register indices, ALUOp/Funct3/Funct7 and stage control bits each cycle.
- Supports stall (hold), flush (bubble insert), and a same-cycle writeback bypass on the operand captures.
- Guarantees that execute never sees a half-updated or stale instruction.

---
 rtl/core_pkg.sv | 39 +++
 rtl/wb_bypass_mux.sv | 27 ++
 rtl/id_ex_reg.sv | 144 ++++++++++++++
 tb/tb_id_ex_reg.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared decode/execute types for the RV32 pipeline: ALUOp and writeback
// select encodings plus the bundled ID/EX control word.
package core_pkg;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_RI  = 2'b10;
  localparam logic [1:0] ALUOP_JL  = 2'b11;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic [1:0] mem_to_reg;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t BUBBLE = id_ex_ctrl_t'(20'd0);

  // An invalid decode slot must never carry live controls into execute.
  function automatic id_ex_ctrl_t gate_ctrl(input logic valid, input id_ex_ctrl_t ctrl);
    if (valid) begin
      return ctrl;
    end else begin
      return BUBBLE;
    end
  endfunction

endpackage

// File: rtl/wb_bypass_mux.sv
// Selects writeback data over register-file read data when writeback targets
// the same source register this cycle; x0 is never forwarded.
module wb_bypass_mux #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_wb_we,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [DATA_W-1:0]     i_rf_data,
  input  logic [DATA_W-1:0]     i_wb_data,
  output logic [DATA_W-1:0]     o_data
);

  logic w_hit;

  // Forward on index match with a live, non-x0 writeback.
  always_comb begin
    w_hit = i_wb_we && (i_wb_rd != {REG_ADDR_W{1'b0}}) && (i_wb_rd == i_rs);
    if (w_hit) begin
      o_data = i_wb_data;
    end else begin
      o_data = i_rf_data;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with stall hold, flush-to-bubble and a
// same-cycle writeback bypass on both operand captures.
module id_ex_reg
  import core_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_pc,
  input  logic [DATA_W-1:0]     in_rd1,
  input  logic [DATA_W-1:0]     in_rd2,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [1:0]            in_alu_op,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic                  in_alu_src,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic                  in_reg_write,
  input  logic                  in_branch,
  input  logic                  in_jump,
  input  logic [1:0]            in_mem_to_reg,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [DATA_W-1:0]     ex_rd1,
  output logic [DATA_W-1:0]     ex_rd2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [1:0]            ex_alu_op,
  output logic [2:0]            ex_funct3,
  output logic [6:0]            ex_funct7,
  output logic                  ex_alu_src,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_reg_write,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic [1:0]            ex_mem_to_reg
);

  logic                  r_valid;
  logic [DATA_W-1:0]     r_pc, r_rd1, r_rd2, r_imm;
  logic [REG_ADDR_W-1:0] r_rs1, r_rs2, r_rd;
  id_ex_ctrl_t           r_ctrl;

  id_ex_ctrl_t           w_raw_ctrl;
  id_ex_ctrl_t           w_cap_ctrl;
  logic [DATA_W-1:0]     w_rd1, w_rd2;

  wb_bypass_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_byp_rs1 (
    .i_wb_we(wb_reg_write), .i_wb_rd(wb_rd), .i_rs(in_rs1),
    .i_rf_data(in_rd1), .i_wb_data(wb_data), .o_data(w_rd1)
  );

  wb_bypass_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_byp_rs2 (
    .i_wb_we(wb_reg_write), .i_wb_rd(wb_rd), .i_rs(in_rs2),
    .i_rf_data(in_rd2), .i_wb_data(wb_data), .o_data(w_rd2)
  );

  // Bundle decode controls so bubbles are one struct assignment.
  always_comb begin
    w_raw_ctrl            = BUBBLE;
    w_raw_ctrl.alu_op     = in_alu_op;
    w_raw_ctrl.funct3     = in_funct3;
    w_raw_ctrl.funct7     = in_funct7;
    w_raw_ctrl.alu_src    = in_alu_src;
    w_raw_ctrl.mem_read   = in_mem_read;
    w_raw_ctrl.mem_write  = in_mem_write;
    w_raw_ctrl.reg_write  = in_reg_write;
    w_raw_ctrl.branch     = in_branch;
    w_raw_ctrl.jump       = in_jump;
    w_raw_ctrl.mem_to_reg = in_mem_to_reg;
  end

  assign w_cap_ctrl = gate_ctrl(in_valid, w_raw_ctrl);

  // Stage register: reset > flush > stall > capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= {DATA_W{1'b0}};
      r_rd1   <= {DATA_W{1'b0}};
      r_rd2   <= {DATA_W{1'b0}};
      r_imm   <= {DATA_W{1'b0}};
      r_rs1   <= {REG_ADDR_W{1'b0}};
      r_rs2   <= {REG_ADDR_W{1'b0}};
      r_rd    <= {REG_ADDR_W{1'b0}};
      r_ctrl  <= BUBBLE;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_pc    <= {DATA_W{1'b0}};
      r_rd1   <= {DATA_W{1'b0}};
      r_rd2   <= {DATA_W{1'b0}};
      r_imm   <= {DATA_W{1'b0}};
      r_rs1   <= {REG_ADDR_W{1'b0}};
      r_rs2   <= {REG_ADDR_W{1'b0}};
      r_rd    <= {REG_ADDR_W{1'b0}};
      r_ctrl  <= BUBBLE;
    end else if (!stall) begin
      r_valid <= in_valid;
      r_pc    <= in_pc;
      r_rd1   <= w_rd1;
      r_rd2   <= w_rd2;
      r_imm   <= in_imm;
      r_rs1   <= in_rs1;
      r_rs2   <= in_rs2;
      r_rd    <= in_rd;
      r_ctrl  <= w_cap_ctrl;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign ex_rd1        = r_rd1;
  assign ex_rd2        = r_rd2;
  assign ex_imm        = r_imm;
  assign ex_rs1        = r_rs1;
  assign ex_rs2        = r_rs2;
  assign ex_rd         = r_rd;
  assign ex_alu_op     = r_ctrl.alu_op;
  assign ex_funct3     = r_ctrl.funct3;
  assign ex_funct7     = r_ctrl.funct7;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_branch     = r_ctrl.branch;
  assign ex_jump       = r_ctrl.jump;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed plus randomized bench for id_ex_reg against a rule-level model of
// the execute-side view of the pipeline register.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        alu_src, mem_read, mem_write, reg_write, branch, jump;
    logic [1:0]  mem_to_reg;
  } ex_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [31:0] in_pc = 32'd0, in_rd1 = 32'd0, in_rd2 = 32'd0, in_imm = 32'd0;
  logic [4:0]  in_rs1 = 5'd0, in_rs2 = 5'd0, in_rd = 5'd0;
  logic [1:0]  in_alu_op = 2'd0, in_mem_to_reg = 2'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [6:0]  in_funct7 = 7'd0;
  logic in_alu_src = 1'b0, in_mem_read = 1'b0, in_mem_write = 1'b0;
  logic in_reg_write = 1'b0, in_branch = 1'b0, in_jump = 1'b0;
  logic        wb_reg_write = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;

  logic        ex_valid;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [1:0]  ex_alu_op, ex_mem_to_reg;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump;

  int vectors = 0;
  int miscompares = 0;
  ex_t exp_s;
  ex_t obs;
  ex_t snap;

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_op(in_alu_op),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_alu_src(in_alu_src),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_reg_write(in_reg_write),
    .in_branch(in_branch), .in_jump(in_jump), .in_mem_to_reg(in_mem_to_reg),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_mem_to_reg(ex_mem_to_reg)
  );

  assign obs = {ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
                ex_alu_op, ex_funct3, ex_funct7, ex_alu_src, ex_mem_read,
                ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_mem_to_reg};

  // What execute should see after the next edge, from the current view and inputs.
  function automatic ex_t next_ex(input ex_t cur);
    ex_t n;
    logic ctl;
    if (flush) return '0;
    if (stall) return cur;
    ctl = in_valid;
    n.valid = in_valid;
    n.pc = in_pc;
    n.imm = in_imm;
    n.rs1 = in_rs1;
    n.rs2 = in_rs2;
    n.rd = in_rd;
    n.rd1 = (wb_reg_write && wb_rd != 5'd0 && wb_rd == in_rs1) ? wb_data : in_rd1;
    n.rd2 = (wb_reg_write && wb_rd != 5'd0 && wb_rd == in_rs2) ? wb_data : in_rd2;
    n.alu_op     = ctl ? in_alu_op : 2'd0;
    n.funct3     = ctl ? in_funct3 : 3'd0;
    n.funct7     = ctl ? in_funct7 : 7'd0;
    n.alu_src    = ctl & in_alu_src;
    n.mem_read   = ctl & in_mem_read;
    n.mem_write  = ctl & in_mem_write;
    n.reg_write  = ctl & in_reg_write;
    n.branch     = ctl & in_branch;
    n.jump       = ctl & in_jump;
    n.mem_to_reg = ctl ? in_mem_to_reg : 2'd0;
    return n;
  endfunction

  task automatic check_all(input string tag);
    vectors++;
    assert (obs === exp_s) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_s);
    end
  endtask

  task automatic check_field(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic tick(input string tag);
    ex_t n;
    n = next_ex(exp_s);
    @(posedge clk);
    #1;
    exp_s = n;
    check_all(tag);
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; in_pc = 32'd0; in_rd1 = 32'd0; in_rd2 = 32'd0; in_imm = 32'd0;
    in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_alu_op = 2'd0; in_funct3 = 3'd0;
    in_funct7 = 7'd0; in_alu_src = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    in_reg_write = 1'b0; in_branch = 1'b0; in_jump = 1'b0; in_mem_to_reg = 2'd0;
    wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
  endtask

  task automatic rand_inputs();
    in_valid = ($urandom_range(0, 4) != 0);
    in_pc = $urandom; in_rd1 = $urandom; in_rd2 = $urandom; in_imm = $urandom;
    in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
    in_rd = 5'($urandom_range(0, 31));
    in_alu_op = 2'($urandom_range(0, 3)); in_funct3 = 3'($urandom_range(0, 7));
    in_funct7 = 7'($urandom_range(0, 127)); in_mem_to_reg = 2'($urandom_range(0, 3));
    in_alu_src = 1'($urandom_range(0, 1)); in_mem_read = 1'($urandom_range(0, 1));
    in_mem_write = 1'($urandom_range(0, 1)); in_reg_write = 1'($urandom_range(0, 1));
    in_branch = 1'($urandom_range(0, 1)); in_jump = 1'($urandom_range(0, 1));
    wb_reg_write = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 7));
    wb_data = $urandom;
  endtask

  initial begin
    exp_s = '0;
    #1 reset = 1'b1;
    #1 check_all("por_reset");
    @(negedge clk);
    reset = 1'b0;
    #1 check_all("por_release");

    // Capture an R-type SUB-like instruction.
    in_valid = 1'b1; in_alu_op = 2'b10; in_funct3 = 3'b000; in_funct7 = 7'b0100000;
    in_rd1 = 32'd5; in_rd2 = 32'd3; in_rd = 5'd7; in_rs1 = 5'd1; in_rs2 = 5'd2;
    in_reg_write = 1'b1; in_pc = 32'h0000_0100;
    tick("capture_add");
    check_field("cap_alu_op", 32'(ex_alu_op), 32'd2);
    check_field("cap_funct7", 32'(ex_funct7), 32'h20);
    check_field("cap_rd1", ex_rd1, 32'd5);
    check_field("cap_rd2", ex_rd2, 32'd3);
    check_field("cap_rd", 32'(ex_rd), 32'd7);
    check_field("cap_reg_write", 32'(ex_reg_write), 32'd1);
    check_field("cap_valid", 32'(ex_valid), 32'd1);

    // Asynchronous reset between edges.
    #3 reset = 1'b1;
    #1 exp_s = '0;
    check_all("reset_async");
    check_field("reset_async_valid", 32'(ex_valid), 32'd0);
    rand_inputs();
    @(posedge clk);
    #1 check_all("reset_held");
    @(negedge clk);
    reset = 1'b0;
    #1 check_all("reset_release");

    // Stall hold for three cycles with changing inputs.
    clear_inputs();
    in_valid = 1'b1; in_pc = 32'h0000_0200; in_rd1 = 32'hA5A5_0001; in_rd = 5'd9;
    in_alu_op = 2'b11; in_jump = 1'b1; in_reg_write = 1'b1; in_mem_to_reg = 2'b10;
    tick("pre_stall");
    snap = exp_s;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      tick("stall_hold");
      check_field("stall_pc", ex_pc, snap.pc);
    end
    stall = 1'b0;
    clear_inputs();
    in_valid = 1'b1; in_pc = 32'h0000_0300; in_imm = 32'hFFFF_FFF0;
    tick("stall_release");
    check_field("stall_release_pc", ex_pc, 32'h0000_0300);

    // Flush beats stall while a store is held.
    clear_inputs();
    in_valid = 1'b1; in_alu_op = 2'b00; in_mem_write = 1'b1; in_alu_src = 1'b1;
    in_funct3 = 3'b010; in_pc = 32'h0000_0400;
    tick("capture_sw");
    check_field("sw_mem_write", 32'(ex_mem_write), 32'd1);
    stall = 1'b1; flush = 1'b1;
    tick("flush_over_stall");
    check_field("flush_valid", 32'(ex_valid), 32'd0);
    check_field("flush_mem_write", 32'(ex_mem_write), 32'd0);
    check_field("flush_alu_op", 32'(ex_alu_op), 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Writeback bypass on both operands, then x0 exclusion.
    clear_inputs();
    in_valid = 1'b1; in_rs1 = 5'd4; in_rs2 = 5'd4; in_rd1 = 32'h11; in_rd2 = 32'h11;
    wb_reg_write = 1'b1; wb_rd = 5'd4; wb_data = 32'hDEAD_BEEF;
    tick("bypass_both");
    check_field("bypass_rd1", ex_rd1, 32'hDEAD_BEEF);
    check_field("bypass_rd2", ex_rd2, 32'hDEAD_BEEF);
    wb_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    tick("bypass_x0");
    check_field("bypass_x0_rd1", ex_rd1, 32'h11);
    wb_rd = 5'd5; in_rs1 = 5'd4; in_rs2 = 5'd5;
    tick("bypass_rs2_only");
    check_field("bypass_only_rd1", ex_rd1, 32'h11);
    check_field("bypass_only_rd2", ex_rd2, 32'hDEAD_BEEF);
    wb_reg_write = 1'b0;
    tick("bypass_no_we");
    check_field("bypass_no_we_rd2", ex_rd2, 32'h11);

    // Invalid capture forces controls low.
    clear_inputs();
    in_valid = 1'b0; in_reg_write = 1'b1; in_branch = 1'b1; in_alu_op = 2'b01;
    tick("invalid_capture");
    check_field("invalid_valid", 32'(ex_valid), 32'd0);
    check_field("invalid_reg_write", 32'(ex_reg_write), 32'd0);
    check_field("invalid_branch", 32'(ex_branch), 32'd0);

    // Randomized stream with stalls and flushes.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
